// File: rtl/vx_dot8_dispatch_pkg.sv
// Shared GPU width constants and batch-dispatch helpers for the DOT8 issue path.
package vx_dot8_dispatch_pkg;

    localparam int DFLT_UUID_WIDTH = 44;
    localparam int DFLT_NW_WIDTH   = 2;
    localparam int DFLT_NR_BITS    = 5;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } dispatch_state_t;

    function automatic int num_pkts(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    function automatic int pid_bits(input int num_threads, input int num_lanes);
        return $clog2(num_threads / num_lanes);
    endfunction

    // A single-batch warp still needs a 1-bit pid port.
    function automatic int pid_width(input int num_threads, input int num_lanes);
        int pb;
        pb = pid_bits(num_threads, num_lanes);
        return (pb < 1) ? 1 : pb;
    endfunction

endpackage

// File: rtl/vx_dot8_batch_find.sv
// Combinational scan of the per-batch nonempty vector: next set index above cur,
// plus the lowest and highest set indices.
module vx_dot8_batch_find #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] cur,
    output logic [W-1:0] next_idx,
    output logic         found,
    output logic [W-1:0] first_idx,
    output logic [W-1:0] last_idx
);

    always_comb begin
        next_idx  = '0;
        found     = 1'b0;
        first_idx = '0;
        last_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) last_idx = W'(i);
        end
        // Descending scan so the lowest qualifying index is the one that sticks.
        for (int unsigned i = N; i > 0; i--) begin
            if (vec[i-1]) begin
                first_idx = W'(i-1);
                if ((i - 1) > 32'(cur)) begin
                    next_idx = W'(i-1);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vx_dot8_dispatch.sv
// Issue-side transmitter for the DOT8 ALU: splits one warp request into
// lane-batch packets with pid/sop/eop on a valid/ready stream.
module vx_dot8_dispatch
    import vx_dot8_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = DFLT_UUID_WIDTH,
    parameter int NW_WIDTH    = DFLT_NW_WIDTH,
    parameter int NR_BITS     = DFLT_NR_BITS,
    parameter int SKIP_EMPTY  = 1,
    localparam int PID_WIDTH  = pid_width(NUM_THREADS, NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [UUID_WIDTH-1:0]       uuid_in,
    input  logic [NW_WIDTH-1:0]         wid_in,
    input  logic [NUM_THREADS-1:0]      tmask_in,
    input  logic [XLEN-1:0]             PC_in,
    input  logic [NR_BITS-1:0]          rd_in,
    input  logic                        wb_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs1_data_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs2_data_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [UUID_WIDTH-1:0]       uuid_out,
    output logic [NW_WIDTH-1:0]         wid_out,
    output logic [NUM_LANES-1:0]        tmask_out,
    output logic [XLEN-1:0]             PC_out,
    output logic [NR_BITS-1:0]          rd_out,
    output logic                        wb_out,
    output logic [PID_WIDTH-1:0]        pid_out,
    output logic                        sop_out,
    output logic                        eop_out,
    output logic [NUM_LANES*XLEN-1:0]   rs1_data_out,
    output logic [NUM_LANES*XLEN-1:0]   rs2_data_out
);

    localparam int NUM_PKTS = num_pkts(NUM_THREADS, NUM_LANES);
    localparam int SLICE_W  = NUM_LANES * XLEN;

    dispatch_state_t state;

    logic [NUM_PKTS-1:0]         ne_in;
    logic [NUM_PKTS-1:0]         ne_r;
    logic [NUM_PKTS-1:0]         find_vec;
    logic [PID_WIDTH-1:0]        last_r;
    logic [NUM_THREADS-1:0]      tmask_r;
    logic [NUM_THREADS*XLEN-1:0] rs1_r;
    logic [NUM_THREADS*XLEN-1:0] rs2_r;

    logic [PID_WIDTH-1:0] nx_idx;
    logic                 nx_found;
    logic [PID_WIDTH-1:0] in_first;
    logic [PID_WIDTH-1:0] in_last;

    logic accept;
    logic fire;
    logic use_latched;

    always_comb begin
        ne_in = '0;
        for (int unsigned b = 0; b < NUM_PKTS; b++) begin
            ne_in[b] = (SKIP_EMPTY == 0) ? 1'b1 : |tmask_in[b*NUM_LANES +: NUM_LANES];
        end
    end

    // One finder serves both uses: an accept only happens when idle or on the
    // eop handshake, and a pid advance only happens mid-request.
    assign use_latched = (state == ST_SEND) && !eop_out;
    assign find_vec    = use_latched ? ne_r : ne_in;

    vx_dot8_batch_find #(
        .N (NUM_PKTS),
        .W (PID_WIDTH)
    ) u_find (
        .vec       (find_vec),
        .cur       (pid_out),
        .next_idx  (nx_idx),
        .found     (nx_found),
        .first_idx (in_first),
        .last_idx  (in_last)
    );

    assign ready_in = (state == ST_IDLE) || (valid_out && ready_out && eop_out);
    assign accept   = valid_in && ready_in;
    assign fire     = valid_out && ready_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            valid_out    <= 1'b0;
            pid_out      <= '0;
            sop_out      <= 1'b0;
            eop_out      <= 1'b0;
            tmask_out    <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            uuid_out     <= '0;
            wid_out      <= '0;
            PC_out       <= '0;
            rd_out       <= '0;
            wb_out       <= 1'b0;
            ne_r         <= '0;
            last_r       <= '0;
            tmask_r      <= '0;
            rs1_r        <= '0;
            rs2_r        <= '0;
        end else if (accept) begin
            state        <= ST_SEND;
            valid_out    <= 1'b1;
            pid_out      <= in_first;
            sop_out      <= 1'b1;
            eop_out      <= (in_first == in_last);
            tmask_out    <= tmask_in[in_first*NUM_LANES +: NUM_LANES];
            rs1_data_out <= rs1_data_in[in_first*SLICE_W +: SLICE_W];
            rs2_data_out <= rs2_data_in[in_first*SLICE_W +: SLICE_W];
            uuid_out     <= uuid_in;
            wid_out      <= wid_in;
            PC_out       <= PC_in;
            rd_out       <= rd_in;
            wb_out       <= wb_in;
            ne_r         <= ne_in;
            last_r       <= in_last;
            tmask_r      <= tmask_in;
            rs1_r        <= rs1_data_in;
            rs2_r        <= rs2_data_in;
        end else if (fire) begin
            if (eop_out) begin
                state     <= ST_IDLE;
                valid_out <= 1'b0;
            end else if (nx_found) begin
                pid_out      <= nx_idx;
                sop_out      <= 1'b0;
                eop_out      <= (nx_idx == last_r);
                tmask_out    <= tmask_r[nx_idx*NUM_LANES +: NUM_LANES];
                rs1_data_out <= rs1_r[nx_idx*SLICE_W +: SLICE_W];
                rs2_data_out <= rs2_r[nx_idx*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: tb/tb_vx_dot8_dispatch.sv
// Directed bench for vx_dot8_dispatch with a packet scoreboard fed at request accept.
module tb_vx_dot8_dispatch;

    localparam int NT = 8;
    localparam int NL = 2;
    localparam int XL = 32;

    typedef struct {
        logic [1:0]  pid;
        logic        sop;
        logic        eop;
        logic [1:0]  tm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [83:0] tag;
    } pkt_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in;
    logic            ready_in;
    logic [43:0]     uuid_in;
    logic [1:0]      wid_in;
    logic [NT-1:0]   tmask_in;
    logic [31:0]     PC_in;
    logic [4:0]      rd_in;
    logic            wb_in;
    logic [NT*XL-1:0] rs1_data_in;
    logic [NT*XL-1:0] rs2_data_in;
    logic            valid_out;
    logic            ready_out;
    logic [43:0]     uuid_out;
    logic [1:0]      wid_out;
    logic [NL-1:0]   tmask_out;
    logic [31:0]     PC_out;
    logic [4:0]      rd_out;
    logic            wb_out;
    logic [1:0]      pid_out;
    logic            sop_out;
    logic            eop_out;
    logic [NL*XL-1:0] rs1_data_out;
    logic [NL*XL-1:0] rs2_data_out;

    pkt_t        exp_q[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    vx_dot8_dispatch #(
        .NUM_THREADS (NT),
        .NUM_LANES   (NL),
        .XLEN        (XL),
        .UUID_WIDTH  (44),
        .NW_WIDTH    (2),
        .NR_BITS     (5),
        .SKIP_EMPTY  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .uuid_in      (uuid_in),
        .wid_in       (wid_in),
        .tmask_in     (tmask_in),
        .PC_in        (PC_in),
        .rd_in        (rd_in),
        .wb_in        (wb_in),
        .rs1_data_in  (rs1_data_in),
        .rs2_data_in  (rs2_data_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .uuid_out     (uuid_out),
        .wid_out      (wid_out),
        .tmask_out    (tmask_out),
        .PC_out       (PC_out),
        .rd_out       (rd_out),
        .wb_out       (wb_out),
        .pid_out      (pid_out),
        .sop_out      (sop_out),
        .eop_out      (eop_out),
        .rs1_data_out (rs1_data_out),
        .rs2_data_out (rs2_data_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] op_a(input logic [31:0] mult, input int th);
        return mult * 32'(th);
    endfunction

    function automatic logic [31:0] op_b(input logic [31:0] mult, input logic [31:0] seed, input int th);
        return ~(mult * 32'(th)) ^ seed;
    endfunction

    // Drive one request, wait (bounded) for acceptance, queue its expected packets.
    task automatic issue(input logic [7:0] tm, input logic [31:0] mult, input logic [31:0] seed);
        int unsigned cyc;
        int          lst[$];
        pkt_t        p;
        logic [83:0] tag;
        cyc = 0;
        for (int t = 0; t < NT; t++) begin
            rs1_data_in[t*XL +: XL] = op_a(mult, t);
            rs2_data_in[t*XL +: XL] = op_b(mult, seed, t);
        end
        uuid_in  = {12'hABC, seed};
        wid_in   = seed[1:0];
        PC_in    = seed ^ 32'h8000_1000;
        rd_in    = seed[6:2];
        wb_in    = seed[7];
        tmask_in = tm;
        valid_in = 1'b1;
        while (!ready_in && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready_in) chk("accept_timeout", ready_in, 1);
        tag = {12'hABC, seed, seed[1:0], seed ^ 32'h8000_1000, seed[6:2], seed[7]};
        for (int b = 0; b < NT/NL; b++) begin
            if (tm[b*NL +: NL] != 2'b00) lst.push_back(b);
        end
        if (lst.size() == 0) lst.push_back(0);
        for (int k = 0; k < lst.size(); k++) begin
            p.pid = 2'(lst[k]);
            p.sop = (k == 0);
            p.eop = (k == lst.size() - 1);
            p.tm  = tm[lst[k]*NL +: NL];
            p.rs1 = {op_a(mult, lst[k]*2 + 1), op_a(mult, lst[k]*2)};
            p.rs2 = {op_b(mult, seed, lst[k]*2 + 1), op_b(mult, seed, lst[k]*2)};
            p.tag = tag;
            exp_q.push_back(p);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned cyc;
        cyc = 0;
        while ((valid_out || exp_q.size() != 0) && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_valid", valid_out, 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Scoreboard: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin : mon
        pkt_t p;
        if (reset === 1'b1 && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pkt", valid_out, 0);
            end else begin
                p = exp_q.pop_front();
                chk("pkt_pid",   pid_out, p.pid);
                chk("pkt_sop",   sop_out, p.sop);
                chk("pkt_eop",   eop_out, p.eop);
                chk("pkt_tmask", tmask_out, p.tm);
                chk("pkt_rs1",   rs1_data_out, p.rs1);
                chk("pkt_rs2",   rs2_data_out, p.rs2);
                chk("pkt_tag",   {uuid_out, wid_out, PC_out, rd_out, wb_out}, p.tag);
            end
        end
    end

    initial begin
        reset       = 1'b0;
        valid_in    = 1'b0;
        ready_out   = 1'b1;
        uuid_in     = '0;
        wid_in      = '0;
        tmask_in    = '0;
        PC_in       = '0;
        rd_in       = '0;
        wb_in       = 1'b0;
        rs1_data_in = '0;
        rs2_data_in = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid",    valid_out, 0);
        chk("rst_pid",      pid_out, 0);
        chk("rst_sop_eop",  {sop_out, eop_out}, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_tag",      {uuid_out, wid_out, PC_out, rd_out, wb_out}, 0);
        chk("rst_data",     {rs1_data_out, rs2_data_out}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full mask: four consecutive packets, ready_in low until eop.
        issue(8'hFF, 32'h0101_0101, 32'h0000_0011);
        chk("t1_valid",     valid_out, 1);
        chk("t1_pid0",      pid_out, 0);
        chk("t1_ready_p0",  ready_in, 0);
        @(posedge clk); #1;
        chk("t1_pid1",      pid_out, 1);
        chk("t1_pid1_rs1",  rs1_data_out, 64'h0303_0303_0202_0202);
        chk("t1_ready_p1",  ready_in, 0);
        @(posedge clk); #1;
        chk("t1_ready_p2",  ready_in, 0);
        @(posedge clk); #1;
        chk("t1_pid3",      pid_out, 3);
        chk("t1_eop3",      eop_out, 1);
        chk("t1_ready_eop", ready_in, 1);
        wait_idle();

        // Single nonempty batch in the middle.
        issue(8'b0011_0000, 32'h1020_3040, 32'h0000_0022);
        chk("t2_pid",     pid_out, 2);
        chk("t2_tmask",   tmask_out, 2'b11);
        chk("t2_sop_eop", {sop_out, eop_out}, 2'b11);
        wait_idle();

        // Empty mask yields one packet; next request accepted on its eop.
        issue(8'h00, 32'h0000_0005, 32'h0000_0033);
        chk("t3_pid",      pid_out, 0);
        chk("t3_tmask",    tmask_out, 2'b00);
        chk("t3_sop_eop",  {sop_out, eop_out}, 2'b11);
        chk("t3_ready_in", ready_in, 1);
        issue(8'b1100_0011, 32'h0707_0707, 32'h0000_0044);
        chk("t3_nobubble_valid", valid_out, 1);
        chk("t3_nobubble_sop",   sop_out, 1);
        chk("t3_nobubble_pid",   pid_out, 0);
        wait_idle();

        // Backpressure on pid 1 for three cycles.
        issue(8'hFF, 32'h0010_0001, 32'h0000_0055);
        @(posedge clk); #1;
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", valid_out, 1);
            chk("t4_hold_pid",   pid_out, 1);
            chk("t4_hold_flags", {sop_out, eop_out}, 2'b00);
            chk("t4_hold_rs1",   rs1_data_out, {op_a(32'h0010_0001, 3), op_a(32'h0010_0001, 2)});
            chk("t4_hold_tmask", tmask_out, 2'b11);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        @(posedge clk); #1;
        chk("t4_advance_pid", pid_out, 2);
        wait_idle();

        // Second request waiting behind a full one.
        issue(8'hFF, 32'h0202_0202, 32'h0000_0066);
        issue(8'b1111_0000, 32'h0303_0303, 32'h0000_0077);
        chk("t5_nobubble_sop", sop_out, 1);
        chk("t5_nobubble_pid", pid_out, 2);
        wait_idle();

        // Asynchronous reset mid-request.
        issue(8'hFF, 32'h0404_0404, 32'h0000_0088);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_pid2", pid_out, 2);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_valid", valid_out, 0);
        chk("t6_async_pid",   pid_out, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t6_ready_in", ready_in, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_residual", valid_out, 0);
        end
        chk("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
